// File: rtl/axonerve_kvs_ctrl_pkg.sv
// Shared definitions for the axonerve_kvs_ctrl_s_axi control slave: register
// addresses, CTRL bit positions, FSM state types and the byte-lane merge helper.
package axonerve_kvs_ctrl_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_GIE      = 6'h04;
  localparam logic [5:0] ADDR_IER      = 6'h08;
  localparam logic [5:0] ADDR_ISR      = 6'h0C;
  localparam logic [5:0] ADDR_DATA_NUM = 6'h10;
  localparam logic [5:0] ADDR_PTR0_LO  = 6'h18;
  localparam logic [5:0] ADDR_PTR0_HI  = 6'h1C;

  // Byte offset bits [1:0] do not take part in decode.
  localparam logic [5:0] ADDR_WORD_MASK = 6'h3C;

  localparam int CTRL_AP_START     = 0;
  localparam int CTRL_AP_DONE      = 1;
  localparam int CTRL_AP_IDLE      = 2;
  localparam int CTRL_AP_READY     = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {
    WRIDLE = 2'd0,
    WRDATA = 2'd1,
    WRRESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RDIDLE = 1'b0,
    RDDATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (new_val & mask) | (old_val & ~mask);
  endfunction

endpackage

// File: rtl/axonerve_kvs_ctrl_s_axi.sv
// AXI4-Lite control slave producing ap_start/data_num/axi00_ptr0 for the KVS kernel.
// Define AXONERVE_KVS_CTRL_IRQ_EN to implement GIE/IER/ISR and the interrupt output.
module axonerve_kvs_ctrl_s_axi
  import axonerve_kvs_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          s_axi_control_awvalid,
  output logic                          s_axi_control_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_awaddr,
  input  logic                          s_axi_control_wvalid,
  output logic                          s_axi_control_wready,
  input  logic [31:0]                   s_axi_control_wdata,
  input  logic [3:0]                    s_axi_control_wstrb,
  output logic                          s_axi_control_bvalid,
  input  logic                          s_axi_control_bready,
  output logic [1:0]                    s_axi_control_bresp,
  input  logic                          s_axi_control_arvalid,
  output logic                          s_axi_control_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_araddr,
  output logic                          s_axi_control_rvalid,
  input  logic                          s_axi_control_rready,
  output logic [31:0]                   s_axi_control_rdata,
  output logic [1:0]                    s_axi_control_rresp,
  output logic                          interrupt,
  output logic                          ap_start,
  input  logic                          ap_idle,
  input  logic                          ap_done,
  output logic [31:0]                   data_num,
  output logic [63:0]                   axi00_ptr0
);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axonerve_kvs_ctrl_s_axi: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (C_S_AXI_ADDR_WIDTH < 6) begin : g_bad_addr_width
    $error("axonerve_kvs_ctrl_s_axi: C_S_AXI_ADDR_WIDTH must be at least 6");
  end

  // Handshake rule on every channel: a transfer happens on the rising edge of
  // ap_clk where valid and ready are both high; ready depends only on FSM state.
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr;
  logic [5:0]  wsel, rsel;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_ctrl, rd_ctrl;
  logic [31:0] rd_mux;

  logic auto_restart, restart_pend, done_flag, ready_flag;
  logic gie;
  logic [1:0] ier, isr;

  assign aw_hs = s_axi_control_awvalid & s_axi_control_awready;
  assign w_hs  = s_axi_control_wvalid & s_axi_control_wready;
  assign ar_hs = s_axi_control_arvalid & s_axi_control_arready;

  assign wsel = waddr[5:0] & ADDR_WORD_MASK;
  assign rsel = s_axi_control_araddr[5:0] & ADDR_WORD_MASK;

  assign wr_ctrl = w_hs && (wsel == ADDR_CTRL);
  assign rd_ctrl = ar_hs && (rsel == ADDR_CTRL);

  assign s_axi_control_bresp = 2'b00;
  assign s_axi_control_rresp = 2'b00;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_state <= WRIDLE;
      rd_state <= RDIDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next               = wr_state;
    s_axi_control_awready = 1'b0;
    s_axi_control_wready  = 1'b0;
    s_axi_control_bvalid  = 1'b0;
    case (wr_state)
      WRIDLE: begin
        s_axi_control_awready = 1'b1;
        if (s_axi_control_awvalid) wr_next = WRDATA;
      end
      WRDATA: begin
        s_axi_control_wready = 1'b1;
        if (s_axi_control_wvalid) wr_next = WRRESP;
      end
      WRRESP: begin
        s_axi_control_bvalid = 1'b1;
        if (s_axi_control_bready) wr_next = WRIDLE;
      end
      default: wr_next = WRIDLE;
    endcase
  end

  always_comb begin
    rd_next               = rd_state;
    s_axi_control_arready = 1'b0;
    s_axi_control_rvalid  = 1'b0;
    case (rd_state)
      RDIDLE: begin
        s_axi_control_arready = 1'b1;
        if (s_axi_control_arvalid) rd_next = RDDATA;
      end
      RDDATA: begin
        s_axi_control_rvalid = 1'b1;
        if (s_axi_control_rready) rd_next = RDIDLE;
      end
      default: rd_next = RDIDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) waddr <= '0;
    else if (aw_hs) waddr <= s_axi_control_awaddr;
  end

  // An ap_done pulse always drops ap_start; with auto_restart it comes back one
  // cycle later so the kernel sees a fresh rising edge. A start write wins.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start     <= 1'b0;
      restart_pend <= 1'b0;
      auto_restart <= 1'b0;
      done_flag    <= 1'b0;
      ready_flag   <= 1'b0;
    end else begin
      if (ap_done) begin
        ap_start     <= 1'b0;
        restart_pend <= auto_restart;
      end else if (restart_pend) begin
        ap_start     <= 1'b1;
        restart_pend <= 1'b0;
      end
      if (wr_ctrl && s_axi_control_wdata[CTRL_AP_START]) ap_start <= 1'b1;
      if (wr_ctrl) auto_restart <= s_axi_control_wdata[CTRL_AUTO_RESTART];
      if (ap_done) begin
        done_flag  <= 1'b1;
        ready_flag <= 1'b1;
      end else if (rd_ctrl) begin
        done_flag  <= 1'b0;
        ready_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      data_num   <= '0;
      axi00_ptr0 <= '0;
    end else if (w_hs) begin
      if (wsel == ADDR_DATA_NUM)
        data_num <= apply_wstrb(data_num, s_axi_control_wdata, s_axi_control_wstrb);
      if (wsel == ADDR_PTR0_LO)
        axi00_ptr0[31:0] <= apply_wstrb(axi00_ptr0[31:0], s_axi_control_wdata,
                                        s_axi_control_wstrb);
      if (wsel == ADDR_PTR0_HI)
        axi00_ptr0[63:32] <= apply_wstrb(axi00_ptr0[63:32], s_axi_control_wdata,
                                         s_axi_control_wstrb);
    end
  end

`ifdef AXONERVE_KVS_CTRL_IRQ_EN
  // A done-driven set takes priority over a host toggle of the same ISR bit.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      gie       <= 1'b0;
      ier       <= 2'b00;
      isr       <= 2'b00;
      interrupt <= 1'b0;
    end else begin
      if (w_hs && (wsel == ADDR_GIE)) gie <= s_axi_control_wdata[0];
      if (w_hs && (wsel == ADDR_IER)) ier <= s_axi_control_wdata[1:0];
      for (int i = 0; i < 2; i++) begin
        if (ap_done && ier[i]) isr[i] <= 1'b1;
        else if (w_hs && (wsel == ADDR_ISR) && s_axi_control_wdata[i]) isr[i] <= ~isr[i];
      end
      interrupt <= gie & |(ier & isr);
    end
  end
`else
  assign gie       = 1'b0;
  assign ier       = 2'b00;
  assign isr       = 2'b00;
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (rsel)
      ADDR_CTRL: begin
        rd_mux[CTRL_AP_START]     = ap_start;
        rd_mux[CTRL_AP_DONE]      = done_flag;
        rd_mux[CTRL_AP_IDLE]      = ap_idle;
        rd_mux[CTRL_AP_READY]     = ready_flag;
        rd_mux[CTRL_AUTO_RESTART] = auto_restart;
      end
      ADDR_GIE:      rd_mux[0]   = gie;
      ADDR_IER:      rd_mux[1:0] = ier;
      ADDR_ISR:      rd_mux[1:0] = isr;
      ADDR_DATA_NUM: rd_mux      = data_num;
      ADDR_PTR0_LO:  rd_mux      = axi00_ptr0[31:0];
      ADDR_PTR0_HI:  rd_mux      = axi00_ptr0[63:32];
      default:       rd_mux      = '0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) s_axi_control_rdata <= '0;
    else if (ar_hs) s_axi_control_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_axonerve_kvs_ctrl_s_axi.sv
// Directed plus randomized bench for axonerve_kvs_ctrl_s_axi with a register-level
// reference model; build with AXONERVE_KVS_CTRL_IRQ_EN to cover the interrupt logic.
module tb_axonerve_kvs_ctrl_s_axi;

`ifdef AXONERVE_KVS_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int LIMIT = 50;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [5:0]  awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [5:0]  araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        interrupt, ap_start;
  logic        ap_idle = 1'b1, ap_done = 1'b0;
  logic [31:0] data_num;
  logic [63:0] axi00_ptr0;

  int checks = 0;
  int errors = 0;

  // Reference model of the host-visible register state.
  logic        m_start, m_done, m_ready, m_auto, m_gie;
  logic [1:0]  m_ier, m_isr;
  logic [31:0] m_data_num;
  logic [63:0] m_ptr;

  always #5 clk = ~clk;

  axonerve_kvs_ctrl_s_axi dut (
    .ap_clk(clk), .areset(areset),
    .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_awaddr(awaddr),
    .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
    .s_axi_control_bresp(bresp),
    .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
    .s_axi_control_araddr(araddr),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .interrupt(interrupt), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .data_num(data_num), .axi00_ptr0(axi00_ptr0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s handshake timeout observed=none expected=handshake", tag);
  endtask

  task automatic model_reset();
    m_start = 0; m_done = 0; m_ready = 0; m_auto = 0; m_gie = 0;
    m_ier = 0; m_isr = 0; m_data_num = 0; m_ptr = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[5:2])
      4'd0: begin
        if (d[0]) m_start = 1'b1;
        m_auto = d[7];
      end
      4'd1: if (IRQ_EN) m_gie = d[0];
      4'd2: if (IRQ_EN) m_ier = d[1:0];
      4'd3: if (IRQ_EN) m_isr = m_isr ^ d[1:0];
      4'd4: m_data_num = merge(m_data_num, d, s);
      4'd6: m_ptr[31:0] = merge(m_ptr[31:0], d, s);
      4'd7: m_ptr[63:32] = merge(m_ptr[63:32], d, s);
      default: ;
    endcase
  endtask

  task automatic model_done();
    m_done = 1'b1;
    m_ready = 1'b1;
    m_start = m_auto;
    if (IRQ_EN) m_isr = m_isr | m_ier;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a[5:2])
      4'd0: r = {24'h0, m_auto, 3'b000, m_ready, ap_idle, m_done, m_start};
      4'd1: r[0] = IRQ_EN & m_gie;
      4'd2: r[1:0] = IRQ_EN ? m_ier : 2'b00;
      4'd3: r[1:0] = IRQ_EN ? m_isr : 2'b00;
      4'd4: r = m_data_num;
      4'd6: r = m_ptr[31:0];
      4'd7: r = m_ptr[63:32];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic model_irq();
    return IRQ_EN & m_gie & |(m_ier & m_isr);
  endfunction

  task automatic aw_phase(input logic [5:0] a);
    int n;
    @(posedge clk); #1;
    awaddr = a;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeout("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    int n;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeout("w");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic b_phase();
    int n;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeout("b");
    check("bresp", bresp, 2'b00);
    @(posedge clk); #1;
    bready = 1'b0;
    check("irq_after_write", interrupt, model_irq());
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_phase(a);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    w_phase(d, s);
    model_write(a, d, s);
    check("wr_data_num", data_num, m_data_num);
    check("wr_ptr0", axi00_ptr0, m_ptr);
    check("wr_ap_start", ap_start, m_start);
    check("wr_bvalid", bvalid, 1'b1);
    b_phase();
  endtask

  task automatic axi_read(input logic [5:0] a, input bit with_done, output logic [31:0] got);
    logic [31:0] exp;
    int n;
    @(posedge clk); #1;
    araddr = a;
    arvalid = 1'b1;
    if (with_done) ap_done = 1'b1;
    exp = model_read(a);
    n = 0;
    @(negedge clk);
    while (!arready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeout("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    ap_done = 1'b0;
    if (with_done) model_done();
    else if (a[5:2] == 4'd0) begin m_done = 1'b0; m_ready = 1'b0; end
    check("rvalid_latency", rvalid, 1'b1);
    got = rdata;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    check("rdata_stable", rdata, got);
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeout("r");
    check("rresp", rresp, 2'b00);
    @(posedge clk); #1;
    rready = 1'b0;
    check("rdata", got, exp);
  endtask

  task automatic pulse_done();
    logic was_auto;
    @(posedge clk); #1;
    ap_done = 1'b1;
    @(posedge clk); #1;
    ap_done = 1'b0;
    was_auto = m_auto;
    model_done();
    if (was_auto) begin
      check("auto_start_gap", ap_start, 1'b0);
      @(posedge clk); #1;
      check("auto_start_back", ap_start, 1'b1);
    end else begin
      check("start_fall", ap_start, 1'b0);
    end
    @(posedge clk); #1;
    check("irq_after_done", interrupt, model_irq());
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    logic [31:0] got;
    logic [5:0] wr_addrs [9];
    wr_addrs = '{6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h3C};
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    check("rst_awready", awready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ap_start", ap_start, 1'b0);
    check("rst_interrupt", interrupt, 1'b0);
    check("rst_data_num", data_num, 32'h0);
    check("rst_ptr0", axi00_ptr0, 64'h0);
    axi_read(6'h00, 1'b0, got);
    check("rst_ctrl", got, 32'h4);
    axi_read(6'h1C, 1'b0, got);
    check("rst_ptr_hi", got, 32'h0);

    // Data registers and byte lanes
    axi_write(6'h10, 32'h0000_4000, 4'hF);
    check("data_num_4000", data_num, 32'h4000);
    axi_write(6'h18, 32'h1000_0000, 4'hF);
    axi_write(6'h1C, 32'h0000_0001, 4'hF);
    check("ptr0_full", axi00_ptr0, 64'h1_1000_0000);
    axi_write(6'h18, 32'hFFFF_FFFF, 4'b0010);
    check("ptr0_lane1", axi00_ptr0[31:0], 32'h1000_FF00);

    // Start / done / clear-on-read
    axi_write(6'h00, 32'h1, 4'hF);
    check("start_set", ap_start, 1'b1);
    pulse_done();
    axi_read(6'h00, 1'b0, got);
    check("ctrl_done_ready", got, 32'hE);
    axi_read(6'h00, 1'b0, got);
    check("ctrl_cleared", got, 32'h4);

    // Auto restart
    axi_write(6'h00, 32'h81, 4'hF);
    pulse_done();
    axi_write(6'h00, 32'h0, 4'hF);
    check("write0_no_clear", ap_start, 1'b1);
    pulse_done();
    axi_read(6'h00, 1'b0, got);

    // Interrupt path (expectations collapse to zero without the IRQ block)
    axi_write(6'h04, 32'h1, 4'hF);
    axi_write(6'h08, 32'h1, 4'hF);
    pulse_done();
`ifdef AXONERVE_KVS_CTRL_IRQ_EN
    check("irq_raised", interrupt, 1'b1);
`endif
    axi_write(6'h0C, 32'h1, 4'hF);
    check("irq_cleared", interrupt, 1'b0);
    axi_read(6'h04, 1'b0, got);
    axi_read(6'h08, 1'b0, got);
    axi_read(6'h00, 1'b0, got);

    // Simultaneous events
    axi_read(6'h00, 1'b1, got);
    check("ctrl_read_pre_set", got, 32'h4);
    axi_read(6'h00, 1'b0, got);
    check("ctrl_set_wins", got, 32'hE);
    aw_phase(6'h00);
    ap_done = 1'b1;
    w_phase(32'h1, 4'hF);
    ap_done = 1'b0;
    model_done();
    model_write(6'h00, 32'h1, 4'hF);
    check("start_write_vs_done", ap_start, 1'b1);
    b_phase();
    pulse_done();
    aw_phase(6'h0C);
    ap_done = 1'b1;
    w_phase(32'h1, 4'hF);
    ap_done = 1'b0;
    model_write(6'h0C, 32'h1, 4'hF);
    model_done();
    b_phase();
    axi_read(6'h0C, 1'b0, got);
`ifdef AXONERVE_KVS_CTRL_IRQ_EN
    check("isr_set_wins", got, 32'h1);
`endif
    axi_read(6'h00, 1'b0, got);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      ap_idle = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1, 2: axi_write(wr_addrs[$urandom_range(0, 8)] | 6'($urandom_range(0, 3)),
                           $urandom, 4'($urandom_range(0, 15)));
        3, 4: axi_read(6'($urandom_range(0, 63)), 1'b0, got);
        default: pulse_done();
      endcase
    end
    ap_idle = 1'b1;

    // Reset in the middle of a write and of a read
    @(posedge clk); #1;
    awaddr = 6'h10;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("wrdata_before_reset", wready, 1'b1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    model_reset();
    check("midrst_wready", wready, 1'b0);
    check("midrst_awready", awready, 1'b1);
    check("midrst_bvalid", bvalid, 1'b0);
    check("midrst_data_num", data_num, 32'h0);
    araddr = 6'h10;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rddata_before_reset", rvalid, 1'b1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    check("midrst_rvalid", rvalid, 1'b0);
    check("midrst_arready", arready, 1'b1);
    check("midrst_rdata", rdata, 32'h0);
    axi_read(6'h00, 1'b0, got);
    check("post_reset_ctrl", got, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
